// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
//   in_valid/in_ready : operand pair handshake (a = minuend, b = subtrahend)
//   out_valid/out_ready : result handshake (diff = a-b mod 2^WIDTH, borrow = a<b)
// master : producer/consumer side driving operands and out_ready
// slave  : the subtractor itself
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_subtractor_if.slave (operand and result handshakes)
// Parameter WIDTH : operand/result width, 2..32.
// Latency from accepting edge to out_valid is exactly WIDTH cycles.
// Optional macro SERIAL_SUBTRACTOR_SAT_EN: when defined, a result with
// borrow=1 is presented as diff=0 (borrow still reported as 1).
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// SHIFT | processing one bit per cycle, LSB first
// DONE  | result held on diff/borrow, out_valid=1
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] diff_r;
  logic             br;
  logic             borrow_r;
  logic [CW-1:0]    cnt;

  logic d;
  logic br_next;
  logic last_bit;

  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // borrow output is a separate register from the running borrow so that it
  // keeps the previous result until the new one is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      diff_r   <= '0;
      br       <= 1'b0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sa    <= bus.a;
            sb    <= bus.b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          br     <= br_next;
          cnt    <= cnt + 1'b1;
          // enters at the MSB; after WIDTH shifts bit 0 has reached diff[0]
          diff_r <= {d, diff_r[WIDTH-1:1]};
          if (last_bit) begin
            borrow_r <= br_next;
            state    <= DONE;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
            if (br_next) diff_r <= '0;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_r;
  assign bus.borrow    = borrow_r;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b present.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  WIDTH  minuend, unsigned.
REQ-007 SHALL have port b  input  WIDTH  subtrahend, unsigned.
REQ-008 SHALL have port out_valid  output  1  diff/borrow hold a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-011 SHALL have port borrow  output  1  final borrow; 1 when a < b.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE, both as decodes of registered state.
REQ-014 SHALL capture a and b into internal shift registers, clear the borrow register and bit counter, and enter SHIFT on a rising edge where state=IDLE and in_valid=1.
REQ-015 SHALL, in SHIFT, process one bit per cycle, LSB first: d = a0 XOR b0 XOR br; br_next = (NOT a0 AND b0) OR (NOT(a0 XOR b0) AND br).
REQ-016 SHALL shift d into diff from the MSB end so that after WIDTH SHIFT cycles diff[0] holds bit 0.
REQ-017 SHALL use a bit counter sized ceil(log2(WIDTH))+1 and leave SHIFT for DONE on the edge that processes bit WIDTH-1.
REQ-018 SHALL assert out_valid exactly WIDTH cycles after the accepting edge, with fixed latency independent of operand values.
REQ-019 SHALL, in DONE, hold diff and borrow stable until a rising edge with out_ready=1, then return to IDLE.
REQ-020 SHALL not accept new operands in the cycle the result is consumed; in_ready rises the cycle after.
REQ-021 SHALL ignore in_valid, a and b outside IDLE; out_ready outside DONE has no effect.
REQ-022 SHALL keep diff/borrow at their last values in IDLE and SHIFT, except during shifting, where diff is internal-progress and is not qualified by out_valid.
REQ-023 SHALL produce diff=0 and borrow=0 for a=b, including a=b=0.
REQ-024 SHALL produce borrow=1 and diff=2^WIDTH+a-b for a<b.

Reset
REQ-025 SHALL, on rst=1 and regardless of clk, force state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, and clear counter and shift registers.
REQ-026 SHALL abort any SHIFT or DONE operation on reset mid-operation, discard the result, and produce no out_valid afterward for it.
REQ-027 SHALL resume normal acceptance on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL provide macro SERIAL_SUBTRACTOR_SAT_EN.
REQ-029 SHALL, with SERIAL_SUBTRACTOR_SAT_EN defined, force diff to all zeros in DONE when borrow=1, with borrow still reported as 1.
REQ-030 SHALL, without SERIAL_SUBTRACTOR_SAT_EN, output the modulo result per REQ-024 with no saturation logic synthesized.

Verification
REQ-031 SHALL cover, with WIDTH=8: a=0x35, b=0x12, out_ready=1 -> out_valid 8 cycles after accept, diff=0x23, borrow=0.
REQ-032 SHALL cover: a=0x12, b=0x35 -> borrow=1 and diff=0xDD, or diff=0x00 with SERIAL_SUBTRACTOR_SAT_EN.
REQ-033 SHALL cover: a=0xFF, b=0x01, then a=0x00, b=0x00 back-to-back with in_valid held high -> 0xFE/0 then 0x00/0; the second accept occurs one cycle after the first consume.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid, diff and borrow stable throughout; the changing a/b/in_valid inputs are ignored.
REQ-035 SHALL cover: rst pulsed asynchronously (mid-cycle) at SHIFT bit 4 -> outputs immediately reset per REQ-025; the next operand pair 0x80-0x01 yields 0x7F, borrow=0.
REQ-036 SHALL cover: a=0x00, b=0xFF -> diff=0x01, borrow=1 (non-SAT build).
